// File: rtl/sd_cic_decimator.sv
// Three-level bitstream to multi-bit word: 3rd-order CIC decimator, ratio 2^LOG2_DECIM.
// Optional round-half-up output stage with positive clamp when SD_DEC_ROUND_EN is defined.
module sd_cic_decimator #(
  parameter int unsigned LOG2_DECIM = 6,
  parameter int unsigned OUT_W      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [1:0]              sd_in,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_valid
);

  localparam int unsigned FULL_W = 3 * LOG2_DECIM + 2;
  localparam int unsigned DROP_W = FULL_W - OUT_W;
  localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;

  generate
    if (LOG2_DECIM < 2 || LOG2_DECIM > 10) begin : g_bad_decim
      $error("LOG2_DECIM must be in 2..10");
    end
    if (OUT_W > FULL_W || OUT_W < 2) begin : g_bad_out_w
      $error("OUT_W must be in 2..FULL_W");
    end
  endgenerate

  logic signed [FULL_W-1:0] integ1, integ2, integ3;
  logic signed [FULL_W-1:0] d1, d2, d3;
  logic [LOG2_DECIM-1:0]    cnt;
  logic                     dec_pend;

  logic signed [FULL_W-1:0] s_c;
  logic signed [FULL_W-1:0] c1_c, c2_c, c3_c;
  logic signed [OUT_W-1:0]  out_word_c;

  // Three-level sample: 00 -> -1, 01/10 -> 0, 11 -> +1
  always_comb begin
    s_c = '0;
    case (sd_in)
      2'b00:   s_c = '1;
      2'b11:   s_c = FULL_W'(1);
      default: s_c = '0;
    endcase
  end

  always_comb begin
    c1_c = integ3 - d1;
    c2_c = c1_c - d2;
    c3_c = c2_c - d3;
  end

  // Reduce the full-width comb result to OUT_W bits
  generate
    if (DROP_W == 0) begin : g_no_drop
      always_comb out_word_c = c3_c;
    end else begin : g_drop
`ifdef SD_DEC_ROUND_EN
      localparam logic [FULL_W:0] RND = (FULL_W + 1)'(1) << (DROP_W - 1);
      logic [FULL_W:0] rnd_sum_c;
      logic            unused_rnd_lsb_c;
      always_comb begin
        rnd_sum_c = {c3_c[FULL_W-1], c3_c} + RND;
        // Adding a positive constant can only overflow upward; clamp to max positive
        if (rnd_sum_c[FULL_W] != rnd_sum_c[FULL_W-1]) begin
          out_word_c = {1'b0, {(OUT_W - 1){1'b1}}};
        end else begin
          out_word_c = rnd_sum_c[FULL_W-1 -: OUT_W];
        end
      end
      assign unused_rnd_lsb_c = ^rnd_sum_c[DROP_W-1:0];
`else
      logic unused_lsb_c;
      always_comb out_word_c = c3_c[FULL_W-1 -: OUT_W];
      assign unused_lsb_c = ^c3_c[DROP_W-1:0];
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      integ1    <= '0;
      integ2    <= '0;
      integ3    <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      cnt       <= '0;
      dec_pend  <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        integ1 <= integ1 + s_c;
        integ2 <= integ2 + integ1;
        integ3 <= integ3 + integ2;
        cnt    <= cnt + LOG2_DECIM'(1);
      end
      dec_pend <= in_valid && (cnt == CNT_LAST);
      // Comb runs one edge after the window closes, on integ3 as captured then
      if (dec_pend) begin
        d1        <= integ3;
        d2        <= c1_c;
        d3        <= c2_c;
        out_data  <= out_word_c;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sd_cic_decimator.sv
// Bench for sd_cic_decimator: pattern table, multi-cycle corner sequences, random stimulus
// against a closed-form CIC model (binomial-weighted sums and third differences).
module tb_sd_cic_decimator;

  localparam int unsigned L  = 6;
  localparam int unsigned OW = 16;
  localparam int unsigned FW = 3 * L + 2;
  localparam int unsigned R  = 1 << L;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 in_valid;
  logic [1:0]           sd_in;
  logic signed [OW-1:0] out_data;
  logic                 out_valid;

  sd_cic_decimator #(.LOG2_DECIM(L), .OUT_W(OW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .sd_in    (sd_in),
    .out_data (out_data),
    .out_valid(out_valid)
  );

  int errors = 0;
  int checks = 0;

  int     smp[$];
  longint xs[$];
  int     cyc = 0;
  int     last_strobe = -1;
  int     strobe_gap = 0;
  bit     due = 1'b0;
  bit     exp_v = 1'b0;
  longint exp_data = 0;
  longint exp_next = 0;

  typedef struct {
    logic [7:0] pat;
    longint     steady;
  } vec_t;

  function automatic longint choose2(longint n);
    return (n < 2) ? 0 : n * (n - 1) / 2;
  endfunction

  // Third integrator after N samples: each sample weighted by C(N-1-i, 2)
  function automatic longint integ3_now();
    longint acc = 0;
    int n = smp.size();
    for (int i = 0; i < n; i++) acc += longint'(smp[i]) * choose2(longint'(n - 1 - i));
    return acc;
  endfunction

  function automatic longint xget(int k);
    return (k < 0) ? 0 : xs[k];
  endfunction

  function automatic longint model_out();
    int m = xs.size();
    longint c3, w, q;
    c3 = xget(m - 1) - 3 * xget(m - 2) + 3 * xget(m - 3) - xget(m - 4);
    w = c3 & ((longint'(1) << FW) - 1);
    if (w >= (longint'(1) << (FW - 1))) w -= (longint'(1) << FW);
`ifdef SD_DEC_ROUND_EN
    if (FW > OW) w += longint'(1) << (FW - OW - 1);
    q = w >>> (FW - OW);
    if (q > (longint'(1) << (OW - 1)) - 1) q = (longint'(1) << (OW - 1)) - 1;
`else
    q = w >>> (FW - OW);
`endif
    return q;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // One clock: drive, update model at the edge, compare 1 time unit later
  task automatic step(input logic v, input logic [1:0] sd, input logic rst);
    reset    = rst;
    in_valid = v;
    sd_in    = sd;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      smp.delete();
      xs.delete();
      due      = 1'b0;
      exp_v    = 1'b0;
      exp_data = 0;
    end else begin
      exp_v = due;
      if (due) exp_data = exp_next;
      due = 1'b0;
      if (v) begin
        smp.push_back((sd == 2'b00) ? -1 : (sd == 2'b11) ? 1 : 0);
        if (smp.size() % R == 0) begin
          xs.push_back(integ3_now());
          exp_next = model_out();
          due = 1'b1;
        end
      end
    end
    #1;
    chk("out_valid", longint'(out_valid), longint'(exp_v));
    chk("out_data", longint'(out_data), exp_data);
    if (out_valid) begin
      if (last_strobe >= 0) strobe_gap = cyc - last_strobe;
      last_strobe = cyc;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 2'b00, 1'b0);
    step(1'b0, 2'b00, 1'b0);
    last_strobe = -1;
    strobe_gap  = 0;
  endtask

  vec_t vecs[5];

  initial begin
    reset = 1'b0; in_valid = 1'b0; sd_in = 2'b00;
    vecs[0] = '{pat: 8'b11_11_11_11, steady: 16384};
    vecs[1] = '{pat: 8'b00_00_00_00, steady: -16384};
    vecs[2] = '{pat: 8'b10_01_10_01, steady: 0};
    vecs[3] = '{pat: 8'b01_11_11_11, steady: 12288};
    vecs[4] = '{pat: 8'b00_11_00_11, steady: 0};

    do_reset();
    chk("reset_out_data", longint'(out_data), 0);
    chk("reset_out_valid", longint'(out_valid), 0);

    // Repeating patterns, continuous in_valid
    for (int t = 0; t < 5; t++) begin
      do_reset();
      for (int i = 0; i < 4 * R; i++) step(1'b1, vecs[t].pat[(i % 4) * 2 +: 2], 1'b1);
      step(1'b0, 2'b00, 1'b1);
      chk($sformatf("steady_vec%0d", t), longint'(out_data), vecs[t].steady);
      chk($sformatf("gap_vec%0d", t), longint'(strobe_gap), longint'(R));
    end

    // Sparse in_valid: one sample every third cycle
    do_reset();
    for (int i = 0; i < 4 * R * 3; i++) step((i % 3) == 0, 2'b11, 1'b1);
    chk("sparse_gap", longint'(strobe_gap), longint'(3 * R));
    chk("sparse_value", longint'(out_data), 16384);

    // Reset mid-window at cnt=30, then a full window after release
    do_reset();
    for (int i = 0; i < 3 * R + 30; i++) step(1'b1, 2'b11, 1'b1);
    step(1'b1, 2'b11, 1'b0);
    chk("midreset_data", longint'(out_data), 0);
    chk("midreset_valid", longint'(out_valid), 0);
    last_strobe = -1;
    for (int i = 0; i < R; i++) step(1'b1, 2'b11, 1'b1);
    chk("post_reset_no_early_strobe", longint'(last_strobe), -1);
    step(1'b0, 2'b11, 1'b1);
    chk("post_reset_first_strobe", longint'(out_valid), 1);

    // Random samples and random gaps against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 1'b1);
    end
    // Biased random so the output sits away from zero
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 4) != 0, ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 2)), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
